// File: rtl/rr_grant_arbiter_8_if.sv
// Requester-side bundle for rr_grant_arbiter_8: enable, request vector, owner release and grant status.
// owner_release carries the owner's "finished" strobe; 'release' is a reserved word in SystemVerilog.
interface rr_grant_arbiter_8_if;
    localparam int unsigned N   = 8;
    localparam int unsigned IDW = 3;

    logic           EN;
    logic [N-1:0]   req;
    logic           owner_release;
    logic [N-1:0]   gnt;
    logic [IDW-1:0] gnt_id;
    logic           gnt_valid;
    logic [IDW-1:0] ptr;
    logic           timeout;

    modport master (
        output EN, req, owner_release,
        input  gnt, gnt_id, gnt_valid, ptr, timeout
    );

    modport slave (
        input  EN, req, owner_release,
        output gnt, gnt_id, gnt_valid, ptr, timeout
    );
endinterface

// File: rtl/rr_grant_arbiter_8.sv
// 8-way round-robin arbiter with a registered one-hot grant held until the owner releases it.
// Optional grant-length limit enabled by defining ARB_TIMEOUT_EN.
module rr_grant_arbiter_8 (
    input  logic                  clk,
    input  logic                  rst,
    rr_grant_arbiter_8_if.slave   bus
);
    localparam int unsigned N   = 8;
    localparam int unsigned IDW = 3;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t         state, state_nx;
    logic [N-1:0]   gnt_q, gnt_nx;
    logic [IDW-1:0] id_q, id_nx;
    logic [IDW-1:0] ptr_q, ptr_nx;
    logic           valid_q, valid_nx;
    logic [IDW-1:0] win, idx;
    logic           win_found;
    logic           owner_end;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned HOLD_MAX = 16;
    localparam int unsigned CNTW     = $clog2(HOLD_MAX);
    logic [CNTW-1:0] cnt_q, cnt_nx;
    logic            to_q, to_nx;
    logic            expired;

    assign expired = (cnt_q == CNTW'(HOLD_MAX - 1));
`endif

    // Lowest rotational offset from ptr wins; scanning high-to-low lets it overwrite last.
    always_comb begin
        win       = '0;
        win_found = 1'b0;
        idx       = '0;
        for (int k = int'(N) - 1; k >= 0; k--) begin
            idx = ptr_q + IDW'(k);
            if (bus.req[idx]) begin
                win       = idx;
                win_found = 1'b1;
            end
        end
    end

    assign owner_end = bus.owner_release | ~bus.req[id_q];

    always_comb begin
        state_nx = state;
        gnt_nx   = gnt_q;
        id_nx    = id_q;
        ptr_nx   = ptr_q;
        valid_nx = valid_q;
`ifdef ARB_TIMEOUT_EN
        cnt_nx   = cnt_q;
        to_nx    = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (bus.EN && win_found) begin
                    state_nx = GRANT;
                    gnt_nx   = N'(1) << win;
                    id_nx    = win;
                    valid_nx = 1'b1;
`ifdef ARB_TIMEOUT_EN
                    cnt_nx   = '0;
`endif
                end
            end
            GRANT: begin
`ifdef ARB_TIMEOUT_EN
                if (owner_end || expired) begin
                    to_nx = ~owner_end;
`else
                if (owner_end) begin
`endif
                    state_nx = IDLE;
                    gnt_nx   = '0;
                    valid_nx = 1'b0;
                    ptr_nx   = id_q + IDW'(1);
                end
`ifdef ARB_TIMEOUT_EN
                else begin
                    cnt_nx = cnt_q + CNTW'(1);
                end
`endif
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            gnt_q   <= '0;
            id_q    <= '0;
            ptr_q   <= '0;
            valid_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            cnt_q   <= '0;
            to_q    <= 1'b0;
`endif
        end else begin
            state   <= state_nx;
            gnt_q   <= gnt_nx;
            id_q    <= id_nx;
            ptr_q   <= ptr_nx;
            valid_q <= valid_nx;
`ifdef ARB_TIMEOUT_EN
            cnt_q   <= cnt_nx;
            to_q    <= to_nx;
`endif
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_id    = id_q;
    assign bus.gnt_valid = valid_q;
    assign bus.ptr       = ptr_q;
`ifdef ARB_TIMEOUT_EN
    assign bus.timeout   = to_q;
`else
    assign bus.timeout   = 1'b0;
`endif
endmodule

// File: tb/tb_rr_grant_arbiter_8.sv
// Directed self-checking bench for rr_grant_arbiter_8 (define ARB_TIMEOUT_EN to cover the hold limit).
module tb_rr_grant_arbiter_8;
    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    rr_grant_arbiter_8_if bus ();

    rr_grant_arbiter_8 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expd);
        n_checks++;
        if (obs !== expd) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expd);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] g, input logic [2:0] id,
                       input logic v, input logic [2:0] p, input logic to);
        check({tag, ".gnt"},       32'(bus.gnt),       32'(g));
        check({tag, ".gnt_id"},    32'(bus.gnt_id),    32'(id));
        check({tag, ".gnt_valid"}, 32'(bus.gnt_valid), 32'(v));
        check({tag, ".ptr"},       32'(bus.ptr),       32'(p));
        check({tag, ".timeout"},   32'(bus.timeout),   32'(to));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        bus.EN            = 1'b0;
        bus.req           = 8'h00;
        bus.owner_release = 1'b0;
        do_reset();
        chk("reset", 8'h00, 3'd0, 1'b0, 3'd0, 1'b0);

        // Basic grant, release, then next requester after the dead cycle
        bus.EN  = 1'b1;
        bus.req = 8'b0000_0101;
        tick(); chk("t1_g0", 8'h01, 3'd0, 1'b1, 3'd0, 1'b0);
        bus.owner_release = 1'b1;
        tick(); chk("t1_rel", 8'h00, 3'd0, 1'b0, 3'd1, 1'b0);
        bus.owner_release = 1'b0;
        tick(); chk("t1_g2", 8'h04, 3'd2, 1'b1, 3'd1, 1'b0);
        bus.req = 8'h00;
        tick(); chk("t1_drop", 8'h00, 3'd2, 1'b0, 3'd3, 1'b0);
        bus.owner_release = 1'b1;
        tick(); chk("idle_rel", 8'h00, 3'd2, 1'b0, 3'd3, 1'b0);
        bus.owner_release = 1'b0;

        // All requesting: strict rotation with one idle cycle between grants
        do_reset();
        bus.req = 8'hFF;
        for (int i = 0; i < 9; i++) begin
            tick(); chk($sformatf("rot%0d_g", i), 8'(1 << (i % 8)), 3'(i % 8), 1'b1, 3'(i % 8), 1'b0);
            bus.owner_release = 1'b1;
            tick(); chk($sformatf("rot%0d_idle", i), 8'h00, 3'(i % 8), 1'b0, 3'((i + 1) % 8), 1'b0);
            bus.owner_release = 1'b0;
        end
        bus.req = 8'h00;
        tick();

        // Owner drops request; other requests ignored while granted
        do_reset();
        bus.req = 8'b0010_1000;
        tick(); chk("drop_g3", 8'h08, 3'd3, 1'b1, 3'd0, 1'b0);
        bus.req = 8'h20;
        tick(); chk("drop_idle", 8'h00, 3'd3, 1'b0, 3'd4, 1'b0);
        tick(); chk("drop_g5", 8'h20, 3'd5, 1'b1, 3'd4, 1'b0);
        bus.req = 8'hFF;
        tick(); chk("hold_g5", 8'h20, 3'd5, 1'b1, 3'd4, 1'b0);
        bus.owner_release = 1'b1;
        tick(); chk("rel_g5", 8'h00, 3'd5, 1'b0, 3'd6, 1'b0);
        bus.owner_release = 1'b0;

        // EN gates new grants only
        bus.EN = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick(); chk($sformatf("en0_%0d", i), 8'h00, 3'd5, 1'b0, 3'd6, 1'b0);
        end
        bus.EN  = 1'b1;
        bus.req = 8'h40;
        tick(); chk("en_g6", 8'h40, 3'd6, 1'b1, 3'd6, 1'b0);
        bus.EN = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(); chk($sformatf("en0_hold%0d", i), 8'h40, 3'd6, 1'b1, 3'd6, 1'b0);
        end
        bus.owner_release = 1'b1;
        tick(); chk("en0_rel", 8'h00, 3'd6, 1'b0, 3'd7, 1'b0);
        bus.owner_release = 1'b0;

        // Asynchronous reset in the middle of a grant
        bus.EN  = 1'b1;
        bus.req = 8'h10;
        tick(); chk("pre_rst_g4", 8'h10, 3'd4, 1'b1, 3'd7, 1'b0);
        #2 rst = 1'b1;
        #1 chk("async_rst", 8'h00, 3'd0, 1'b0, 3'd0, 1'b0);
        tick();
        rst = 1'b0;
        tick(); chk("post_rst_g4", 8'h10, 3'd4, 1'b1, 3'd0, 1'b0);
        bus.req = 8'h00;
        tick(); chk("post_rst_drop", 8'h00, 3'd4, 1'b0, 3'd5, 1'b0);

`ifdef ARB_TIMEOUT_EN
        // Hold limit: revoke after 16 grant cycles, then release wins on the revoke edge
        do_reset();
        bus.req = 8'h04;
        tick(); chk("to_g2", 8'h04, 3'd2, 1'b1, 3'd0, 1'b0);
        for (int k = 1; k < 16; k++) begin
            tick(); chk($sformatf("to_hold%0d", k), 8'h04, 3'd2, 1'b1, 3'd0, 1'b0);
        end
        tick(); chk("to_revoke", 8'h00, 3'd2, 1'b0, 3'd3, 1'b1);
        tick(); chk("to_regrant", 8'h04, 3'd2, 1'b1, 3'd3, 1'b0);
        for (int k = 1; k < 16; k++) begin
            tick(); chk($sformatf("to2_hold%0d", k), 8'h04, 3'd2, 1'b1, 3'd3, 1'b0);
        end
        bus.owner_release = 1'b1;
        tick(); chk("to_rel_wins", 8'h00, 3'd2, 1'b0, 3'd3, 1'b0);
        bus.owner_release = 1'b0;
        bus.req = 8'h00;
        tick(); chk("to_after", 8'h00, 3'd2, 1'b0, 3'd3, 1'b0);
`else
        // Without the hold limit a grant lasts as long as the owner wants it
        do_reset();
        bus.req = 8'h04;
        tick(); chk("nto_g2", 8'h04, 3'd2, 1'b1, 3'd0, 1'b0);
        for (int k = 1; k < 20; k++) tick();
        chk("nto_hold", 8'h04, 3'd2, 1'b1, 3'd0, 1'b0);
        bus.owner_release = 1'b1;
        tick(); chk("nto_rel", 8'h00, 3'd2, 1'b0, 3'd3, 1'b0);
        bus.owner_release = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
